// File: rtl/wb_fml_bridge_pkg.sv
// Shared FML constants and the bridge state encoding.
package wb_fml_bridge_pkg;

   localparam int FML_ADR_W     = 22;
   localparam int FML_DAT_W     = 32;
   localparam int FML_BE_W      = 4;
   localparam int FML_BURST_LEN = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR_PUSH,
      WR_REQ,
      RD_REQ,
      RD_POP,
      ACK
   } state_t;

endpackage

// File: rtl/wb_fml_bridge_if.sv
// Wishbone slave plus FML initiator signal bundle; "slave" is the bridge side.
interface wb_fml_bridge_if;
   import wb_fml_bridge_pkg::*;

   logic                 wb_cyc_i;
   logic                 wb_stb_i;
   logic                 wb_we_i;
   logic [31:0]          wb_adr_i;
   logic [3:0]           wb_sel_i;
   logic [31:0]          wb_dat_i;
   logic [31:0]          wb_dat_o;
   logic                 wb_ack_o;

   logic [FML_ADR_W-1:0] fml_adr;
   logic                 fml_rd;
   logic                 fml_wr;
   logic                 fml_done;
   logic [FML_DAT_W-1:0] fml_wdat;
   logic [FML_BE_W-1:0]  fml_wbe;
   logic                 fml_wnext;
   logic                 fml_rempty;
   logic                 fml_rnext;
   logic [FML_DAT_W-1:0] fml_rdat;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o,
      output fml_adr, fml_rd, fml_wr, fml_wdat, fml_wbe, fml_wnext, fml_rnext,
      input  fml_done, fml_rempty, fml_rdat
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o,
      input  fml_adr, fml_rd, fml_wr, fml_wdat, fml_wbe, fml_wnext, fml_rnext,
      output fml_done, fml_rempty, fml_rdat
   );

endinterface

// File: rtl/wb_fml_bridge_line_buf.sv
// Single-line read buffer: tag, valid bit and four words with a byte-masked write port.
module fml_line_buf
   import wb_fml_bridge_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [FML_ADR_W-1:0] lookup_tag,
   input  logic [1:0]           rd_idx,
   output logic                 hit,
   output logic [FML_DAT_W-1:0] rd_dat,
   input  logic                 inval,
   input  logic                 set_valid,
   input  logic [FML_ADR_W-1:0] set_tag,
   input  logic                 wr_en,
   input  logic [1:0]           wr_idx,
   input  logic [FML_BE_W-1:0]  wr_be,
   input  logic [FML_DAT_W-1:0] wr_dat
);

   logic                 valid_q;
   logic [FML_ADR_W-1:0] tag_q;
   logic [FML_DAT_W-1:0] line_q [FML_BURST_LEN];

   assign hit    = valid_q & (tag_q == lookup_tag);
   assign rd_dat = line_q[rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else if (inval) begin
         valid_q <= 1'b0;
      end else if (set_valid) begin
         valid_q <= 1'b1;
         tag_q   <= set_tag;
      end
   end

   // Storage needs no reset: it is only read behind a valid tag.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < FML_BE_W; b++) begin
            if (wr_be[b]) line_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/wb_fml_bridge.sv
// Wishbone classic slave issuing one 4-word FML burst per access.
// Define WB_FML_RBUF_EN to add a single-line read buffer in front of FML.
module wb_fml_bridge
   import wb_fml_bridge_pkg::*;
(
   input logic            clk,
   input logic            reset,
   wb_fml_bridge_if.slave bus
);

   // state   | meaning
   // IDLE    | waiting for a Wishbone strobe
   // WR_PUSH | pushing 4 write words, only word w carries byte enables
   // WR_REQ  | fml_wr held until fml_done
   // RD_REQ  | fml_rd held until fml_done
   // RD_POP  | draining 4 read words as the FIFO offers them, capturing word w
   // ACK     | one-cycle Wishbone acknowledge

   state_t      state;
   logic [1:0]  w_q;
   logic [1:0]  cnt;
   logic [1:0]  pop_idx;
   logic [1:0]  k_next;
   logic [3:0]  sel_q;
   logic        ack_q;
   logic        accept;
   logic        hit;
   logic [31:0] buf_rdat;
   logic        unused_adr;

   assign unused_adr = ^{bus.wb_adr_i[31:FML_ADR_W+4], bus.wb_adr_i[1:0]};

   // cnt counts words still to move after the current one
   assign pop_idx = 2'd3 - cnt;
   assign k_next  = 2'd0 - cnt;
   assign accept  = (state == IDLE) & bus.wb_cyc_i & bus.wb_stb_i;

   assign bus.fml_rnext = (state == RD_POP) & ~bus.fml_rempty;
   assign bus.wb_ack_o  = ack_q & bus.wb_cyc_i;

`ifdef WB_FML_RBUF_EN
   logic lb_fill;
   assign lb_fill = (state == RD_POP);

   fml_line_buf u_line_buf (
      .clk        (clk),
      .reset      (reset),
      .lookup_tag (bus.wb_adr_i[FML_ADR_W+3:4]),
      .rd_idx     (bus.wb_adr_i[3:2]),
      .hit        (hit),
      .rd_dat     (buf_rdat),
      .inval      (accept & ~bus.wb_we_i & ~hit),
      .set_valid  (bus.fml_rnext & (cnt == 2'd0)),
      .set_tag    (bus.fml_adr),
      .wr_en      ((accept & bus.wb_we_i & hit) | bus.fml_rnext),
      .wr_idx     (lb_fill ? pop_idx : bus.wb_adr_i[3:2]),
      .wr_be      (lb_fill ? 4'hF : bus.wb_sel_i),
      .wr_dat     (lb_fill ? bus.fml_rdat : bus.wb_dat_i)
   );
`else
   assign hit      = 1'b0;
   assign buf_rdat = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ack_q         <= 1'b0;
         w_q           <= '0;
         cnt           <= '0;
         sel_q         <= '0;
         bus.wb_dat_o  <= '0;
         bus.fml_adr   <= '0;
         bus.fml_rd    <= 1'b0;
         bus.fml_wr    <= 1'b0;
         bus.fml_wnext <= 1'b0;
         bus.fml_wdat  <= '0;
         bus.fml_wbe   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.fml_adr <= bus.wb_adr_i[FML_ADR_W+3:4];
                  w_q         <= bus.wb_adr_i[3:2];
                  sel_q       <= bus.wb_sel_i;
                  if (bus.wb_we_i) begin
                     bus.fml_wdat  <= bus.wb_dat_i;
                     bus.fml_wnext <= 1'b1;
                     bus.fml_wbe   <= (bus.wb_adr_i[3:2] == 2'd0) ? bus.wb_sel_i : 4'b0000;
                     cnt           <= 2'd3;
                     state         <= WR_PUSH;
                  end else if (hit) begin
                     bus.wb_dat_o <= buf_rdat;
                     ack_q        <= 1'b1;
                     state        <= ACK;
                  end else begin
                     bus.fml_rd <= 1'b1;
                     state      <= RD_REQ;
                  end
               end
            end
            WR_PUSH: begin
               if (cnt == 2'd0) begin
                  bus.fml_wnext <= 1'b0;
                  bus.fml_wbe   <= 4'b0000;
                  bus.fml_wr    <= 1'b1;
                  state         <= WR_REQ;
               end else begin
                  cnt         <= cnt - 2'd1;
                  bus.fml_wbe <= (k_next == w_q) ? sel_q : 4'b0000;
               end
            end
            WR_REQ: begin
               if (bus.fml_done) begin
                  bus.fml_wr <= 1'b0;
                  ack_q      <= 1'b1;
                  state      <= ACK;
               end
            end
            RD_REQ: begin
               if (bus.fml_done) begin
                  bus.fml_rd <= 1'b0;
                  cnt        <= 2'd3;
                  state      <= RD_POP;
               end
            end
            RD_POP: begin
               if (bus.fml_rnext) begin
                  if (pop_idx == w_q) bus.wb_dat_o <= bus.fml_rdat;
                  if (cnt == 2'd0) begin
                     ack_q <= 1'b1;
                     state <= ACK;
                  end else begin
                     cnt <= cnt - 2'd1;
                  end
               end
            end
            ACK: begin
               ack_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_fml_bridge.sv
// Directed bench for wb_fml_bridge: vector table of single accesses plus reset and buffer sequences.
module tb_wb_fml_bridge;
   import wb_fml_bridge_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   wb_fml_bridge_if bus ();

   wb_fml_bridge dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          d;
      int          gap_at;
      logic [31:0] rbase;
      logic        drop;
      logic        hit;
      int          budget;
      int          exp_lat;
      logic [15:0] exp_wbe;
      logic [21:0] exp_fadr;
      logic [31:0] exp_dat;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input int d, input int gap_at,
                               input logic [31:0] rbase, input logic drop, input logic hit,
                               input int budget, input int exp_lat, input logic [15:0] exp_wbe,
                               input logic [21:0] exp_fadr, input logic [31:0] exp_dat);
      vec_t v;
      v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.d = d; v.gap_at = gap_at;
      v.rbase = rbase; v.drop = drop; v.hit = hit; v.budget = budget; v.exp_lat = exp_lat;
      v.exp_wbe = exp_wbe; v.exp_fadr = exp_fadr; v.exp_dat = exp_dat;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one Wishbone access and plays the FML controller: fml_done in the
   // d-th cycle a request is high, read words rbase+i with an optional empty cycle.
   task automatic run_access(input string tag, input vec_t v);
      int          pushes, pops, wr_hi, rd_hi, ack_at, ptr;
      logic [15:0] wbe_seq;
      logic        wdat_ok, pop_empty, taken, gap_done;
      logic [31:0] rdat_cap;
      logic [21:0] adr_seen;
      pushes = 0; pops = 0; wr_hi = 0; rd_hi = 0; ack_at = -1; ptr = 0;
      wbe_seq = '0; wdat_ok = 1'b1; pop_empty = 1'b0; taken = 1'b0; gap_done = 1'b0;
      rdat_cap = '0; adr_seen = '0;

      @(negedge clk);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = v.we;
      bus.wb_adr_i = v.adr; bus.wb_sel_i = v.sel; bus.wb_dat_i = v.dat;
      bus.fml_done = 1'b0; bus.fml_rempty = 1'b1;

      for (int t = 1; t <= v.budget && ack_at < 0; t++) begin
         @(posedge clk);
         if (t == 1 && v.drop) begin
            #1;
            bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
         end
         @(negedge clk);
         bus.fml_done = 1'b0;
         if (bus.fml_wnext) begin
            wbe_seq = {wbe_seq[11:0], bus.fml_wbe};
            if (bus.fml_wdat !== v.dat) wdat_ok = 1'b0;
            pushes++;
         end
         if (taken && ptr < 4 && !(ptr == v.gap_at && !gap_done)) begin
            bus.fml_rempty = 1'b0;
            bus.fml_rdat   = v.rbase + ptr;
         end else begin
            bus.fml_rempty = 1'b1;
            if (taken && ptr == v.gap_at) gap_done = 1'b1;
         end
         if (bus.fml_wr || bus.fml_rd) adr_seen = bus.fml_adr;
         if (bus.fml_wr) begin
            wr_hi++;
            if (wr_hi == v.d) bus.fml_done = 1'b1;
         end
         if (bus.fml_rd) begin
            rd_hi++;
            if (rd_hi == v.d) begin
               bus.fml_done = 1'b1;
               taken = 1'b1;
            end
         end
         #1;
         if (bus.fml_rnext) begin
            if (bus.fml_rempty) pop_empty = 1'b1;
            pops++;
            ptr++;
         end
         if (bus.wb_ack_o) begin
            ack_at   = t;
            rdat_cap = bus.wb_dat_o;
         end
      end

      if (ack_at >= 0) begin
         @(posedge clk);
         #1;
         bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
         @(negedge clk);
         check({tag, " ack_single"}, 64'(bus.wb_ack_o), 64'd0);
      end
      bus.fml_done = 1'b0; bus.fml_rempty = 1'b1;

      check({tag, " ack_lat"}, 64'(ack_at), 64'(v.exp_lat));
      if (v.we) begin
         check({tag, " pushes"}, 64'(pushes), 64'd4);
         check({tag, " wbe_seq"}, 64'(wbe_seq), 64'(v.exp_wbe));
         check({tag, " wdat"}, 64'(wdat_ok), 64'd1);
         check({tag, " wr_cycles"}, 64'(wr_hi), 64'(v.d));
         check({tag, " fml_adr"}, 64'(adr_seen), 64'(v.exp_fadr));
      end else begin
         check({tag, " pops"}, 64'(pops), v.hit ? 64'd0 : 64'd4);
         check({tag, " pop_empty"}, 64'(pop_empty), 64'd0);
         check({tag, " rd_cycles"}, 64'(rd_hi), 64'(v.d));
         check({tag, " rdata"}, 64'(rdat_cap), 64'(v.exp_dat));
         if (!v.hit) check({tag, " fml_adr"}, 64'(adr_seen), 64'(v.exp_fadr));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      vec_t vt[8];
      int   pops;
      logic taken, bad;

      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
      bus.fml_done = 1'b0; bus.fml_rempty = 1'b1; bus.fml_rdat = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset ctrl", 64'({bus.wb_ack_o, bus.fml_rd, bus.fml_wr, bus.fml_wnext, bus.fml_rnext,
                               bus.fml_wbe, bus.fml_adr}), 64'd0);
      check("reset data", {bus.wb_dat_o, bus.fml_wdat}, 64'd0);

      //         we  adr            sel   dat            d  gap rbase          drop hit bud lat  wbe       fadr        dat
      vt[0] = mk(1, 32'h0000_0024, 4'hF, 32'hDEAD_BEEF, 3, -1, 32'h0,        0,   0,  40, 8,  16'h0F00, 22'h2,      32'h0);
      vt[1] = mk(0, 32'h0000_003C, 4'hF, 32'h0,        2,  2, 32'hA0,       0,   0,  40, 8,  16'h0,    22'h3,      32'hA3);
      vt[2] = mk(1, 32'h0000_0104, 4'h2, 32'h0000_AB00, 1, -1, 32'h0,        0,   0,  40, 6,  16'h0200, 22'h10,     32'h0);
      vt[3] = mk(0, 32'h0000_1000, 4'hF, 32'h0,        1, -1, 32'h1111_0000, 0,   0,  40, 6,  16'h0,    22'h100,    32'h1111_0000);
      vt[4] = mk(1, 32'h3FFF_FFC8, 4'h9, 32'hCAFE_F00D, 1, -1, 32'h0,        0,   0,  40, 6,  16'h0090, 22'h3FFFFC, 32'h0);
      vt[5] = mk(0, 32'h0000_0058, 4'hF, 32'h0,        4,  0, 32'h5550,     0,   0,  40, 10, 16'h0,    22'h5,      32'h5552);
      vt[6] = mk(1, 32'h0000_0200, 4'hF, 32'h0000_0001, 50, -1, 32'h0,       0,   0,  80, 55, 16'hF000, 22'h20,     32'h0);
      vt[7] = mk(1, 32'h0000_0300, 4'hF, 32'h0000_0002, 1, -1, 32'h0,        1,   0,  15, -1, 16'hF000, 22'h30,     32'h0);

      for (int i = 0; i < 8; i++) run_access($sformatf("v%0d", i), vt[i]);

      // Reset while draining a read, after two words were popped.
      @(negedge clk);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = 32'h0000_07A0; bus.wb_sel_i = 4'hF;
      pops = 0; taken = 1'b0;
      for (int t = 1; t <= 20 && pops < 2; t++) begin
         @(posedge clk);
         @(negedge clk);
         bus.fml_done = 1'b0;
         if (taken) begin
            bus.fml_rempty = 1'b0;
            bus.fml_rdat   = 32'hC0C0_0000 + pops;
         end else begin
            bus.fml_rempty = 1'b1;
         end
         if (bus.fml_rd) begin
            bus.fml_done = 1'b1;
            taken = 1'b1;
         end
         #1;
         if (bus.fml_rnext) pops++;
      end
      @(posedge clk);
      #1;
      bus.fml_rempty = 1'b1;
      @(negedge clk);
      check("rst pops", 64'(pops), 64'd2);
      check("rst pre dat", 64'(bus.wb_dat_o), 64'hC0C0_0000);
      reset = 1'b1;
      @(posedge clk);
      #1;
      bus.fml_rempty = 1'b0;
      @(negedge clk);
      check("rst ctrl", 64'({bus.wb_ack_o, bus.fml_rd, bus.fml_wr, bus.fml_wnext, bus.fml_rnext,
                             bus.fml_wbe, bus.fml_adr}), 64'd0);
      check("rst data", {bus.wb_dat_o, bus.fml_wdat}, 64'd0);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.fml_rempty = 1'b1;
      reset = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.wb_ack_o || bus.fml_rd || bus.fml_wr || bus.fml_rnext) bad = 1'b1;
      end
      check("rst quiet", 64'(bad), 64'd0);

`ifdef WB_FML_RBUF_EN
      run_access("rb miss", mk(0, 32'h40, 4'hF, 32'h0, 1, -1, 32'hB0, 0, 0, 40, 6, 16'h0, 22'h4, 32'hB0));
      run_access("rb hit", mk(0, 32'h44, 4'hF, 32'h0, 0, -1, 32'h0, 0, 1, 40, 1, 16'h0, 22'h4, 32'hB1));
      run_access("rb wr", mk(1, 32'h44, 4'hF, 32'h1234_5678, 1, -1, 32'h0, 0, 0, 40, 6, 16'h0F00, 22'h4, 32'h0));
      run_access("rb hit2", mk(0, 32'h44, 4'hF, 32'h0, 0, -1, 32'h0, 0, 1, 40, 1, 16'h0, 22'h4, 32'h1234_5678));
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
